// File: rtl/mcu_pkg.sv
// Shared types and helpers for the multi-cycle execute controller.
package mcu_pkg;

   localparam int unsigned STALL_CNT_W = 32;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StWait  = 2'd1,
      StDone  = 2'd2,
      StDrain = 2'd3
   } mcu_state_e;

   // $clog2 that never returns less than 1, so select buses are never zero-width.
   function automatic int unsigned clog2_min1(input int unsigned n);
      int unsigned r;
      r = (n <= 32'd2) ? 32'd1 : 32'($clog2(n));
      return r;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; used for stall accounting and the watchdog.
module sat_counter #(
   parameter int unsigned W = 32
) (
   input  logic         clk_i,
   input  logic         reset_ni,
   input  logic         clr_i,
   input  logic         inc_i,
   output logic [W-1:0] count_o
);

   logic [W-1:0] count_d, count_q;

   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (inc_i && (count_q != '1)) begin
         count_d = count_q + W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/multicycle_exec_ctrl.sv
// Execute-stage sequencer for multi-cycle functional units: launch, stall, capture, flush/drain.
// Optional watchdog enabled by defining MCU_TIMEOUT_EN.
module multicycle_exec_ctrl
   import mcu_pkg::*;
#(
   parameter int unsigned NUM_UNITS      = 2,
   parameter int unsigned WIDTH          = 64,
   parameter int unsigned SEL_W          = clog2_min1(NUM_UNITS),
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic                       clk_i,
   input  logic                       reset_ni,
   input  logic                       issue_valid_i,
   input  logic [SEL_W-1:0]           issue_unit_i,
   input  logic                       flush_i,
   output logic [NUM_UNITS-1:0]       unit_start_o,
   input  logic [NUM_UNITS-1:0]       unit_done_i,
   input  logic [NUM_UNITS*WIDTH-1:0] unit_result_i,
   output logic                       stall_o,
   output logic [WIDTH-1:0]           result_o,
   output logic                       result_valid_o,
   output logic                       issue_err_o,
   output logic                       timeout_o,
   output logic [STALL_CNT_W-1:0]     stall_cycles_o
);

   mcu_state_e       state_d, state_q;
   logic [SEL_W-1:0] sel_d, sel_q;
   logic [WIDTH-1:0] result_d, result_q;
   logic             issue_ok;
   logic             launch;
   logic             sel_done;
   logic [WIDTH-1:0] sel_result;
   logic             timeout_hit;

   assign issue_ok = (32'(issue_unit_i) < NUM_UNITS);

   always_comb begin
      sel_done   = 1'b0;
      sel_result = '0;
      for (int unsigned i = 0; i < NUM_UNITS; i++) begin
         if (sel_q == SEL_W'(i)) begin
            sel_done   = unit_done_i[i];
            sel_result = unit_result_i[i*WIDTH +: WIDTH];
         end
      end
   end

   always_comb begin
      unit_start_o = '0;
      for (int unsigned i = 0; i < NUM_UNITS; i++) begin
         unit_start_o[i] = launch && (issue_unit_i == SEL_W'(i));
      end
   end

   always_comb begin
      state_d        = state_q;
      sel_d          = sel_q;
      result_d       = result_q;
      launch         = 1'b0;
      stall_o        = 1'b0;
      result_valid_o = 1'b0;
      issue_err_o    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (issue_valid_i) begin
               if (issue_ok) begin
                  launch  = 1'b1;
                  stall_o = 1'b1;
                  sel_d   = issue_unit_i;
                  state_d = StWait;
               end else begin
                  issue_err_o = 1'b1;
               end
            end
         end
         StWait: begin
            stall_o = 1'b1;
            // A squash beats a coincident completion; the result is dropped.
            if (flush_i) begin
               state_d = sel_done ? StIdle : StDrain;
            end else if (sel_done) begin
               result_d = sel_result;
               state_d  = StDone;
            end else if (timeout_hit) begin
               result_d = '0;
               state_d  = StDrain;
            end
         end
         StDone: begin
            result_valid_o = !flush_i;
            state_d        = StIdle;
         end
         StDrain: begin
            stall_o = issue_valid_i;
            if (sel_done) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         state_q  <= StIdle;
         sel_q    <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         result_q <= result_d;
      end
   end

   assign result_o = result_q;

   sat_counter #(
      .W(STALL_CNT_W)
   ) u_stall_cnt (
      .clk_i   (clk_i),
      .reset_ni(reset_ni),
      .clr_i   (1'b0),
      .inc_i   (stall_o),
      .count_o (stall_cycles_o)
   );

`ifdef MCU_TIMEOUT_EN
   localparam int unsigned WdgW = clog2_min1(TIMEOUT_CYCLES + 1);

   logic [WdgW-1:0] wdg_cnt;
   logic            timeout_d, timeout_q;

   // Count holds at zero outside WAIT, so it restarts on every entry.
   sat_counter #(
      .W(WdgW)
   ) u_wdg (
      .clk_i   (clk_i),
      .reset_ni(reset_ni),
      .clr_i   (state_q != StWait),
      .inc_i   (state_q == StWait),
      .count_o (wdg_cnt)
   );

   assign timeout_hit = (wdg_cnt == WdgW'(TIMEOUT_CYCLES - 1));
   assign timeout_d   = (state_q == StWait) && !flush_i && !sel_done && timeout_hit;

   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         timeout_q <= 1'b0;
      end else begin
         timeout_q <= timeout_d;
      end
   end

   assign timeout_o = timeout_q;
`else
   assign timeout_hit = 1'b0;
   assign timeout_o   = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_exec_ctrl.sv
// Scoreboard bench for multicycle_exec_ctrl (3 units, 64-bit results, 8-cycle watchdog).
module tb_multicycle_exec_ctrl;

   localparam int unsigned NU = 3;
   localparam int unsigned W  = 64;

   logic          clk;
   logic          reset_n;
   logic          issue_valid;
   logic [1:0]    issue_unit;
   logic          flush;
   logic [NU-1:0] unit_start;
   logic [NU-1:0] unit_done;
   logic [NU*W-1:0] unit_result;
   logic          stall;
   logic [W-1:0]  result;
   logic          result_valid;
   logic          issue_err;
   logic          timeout;
   logic [31:0]   stall_cycles;

   int          checks;
   int          errors;
   int unsigned exp_sc;
   logic [W-1:0] sb_q[$];
   logic [W-1:0] exp_res;

   multicycle_exec_ctrl #(
      .NUM_UNITS     (NU),
      .WIDTH         (W),
      .TIMEOUT_CYCLES(8)
   ) dut (
      .clk_i         (clk),
      .reset_ni      (reset_n),
      .issue_valid_i (issue_valid),
      .issue_unit_i  (issue_unit),
      .flush_i       (flush),
      .unit_start_o  (unit_start),
      .unit_done_i   (unit_done),
      .unit_result_i (unit_result),
      .stall_o       (stall),
      .result_o      (result),
      .result_valid_o(result_valid),
      .issue_err_o   (issue_err),
      .timeout_o     (timeout),
      .stall_cycles_o(stall_cycles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation did not end by itself");
      $fatal(1, "simulation time limit exceeded");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; issue_valid = 1'b0; issue_unit = '0; flush = 1'b0;
      unit_done = '0; unit_result = '0;
      tick(); tick();
      reset_n = 1'b1;
      #1;
      checks++; if (unit_start !== 3'b000) begin errors++; $display("FAIL reset_start: got %b want 000", unit_start); end
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
      checks++; if (result !== 64'd0) begin errors++; $display("FAIL reset_result: got %h want 0", result); end
      checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL reset_rv: got %b want 0", result_valid); end
      checks++; if (issue_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", issue_err); end
      checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", timeout); end
      checks++; if (stall_cycles !== 32'd0) begin errors++; $display("FAIL reset_stall_cycles: got %0d want 0", stall_cycles); end
      exp_sc = 0;
   endtask

   task automatic test_basic();
      tick();
      issue_valid = 1'b1; issue_unit = 2'd1;
      unit_result[1*W +: W] = 64'hDEAD_BEEF;
      sb_q.push_back(64'hDEAD_BEEF);
      #1;
      checks++; if (unit_start !== 3'b010) begin errors++; $display("FAIL basic_start: got %b want 010", unit_start); end
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL basic_stall0: got %b want 1", stall); end
      for (int i = 1; i <= 3; i++) begin
         tick();
         if (i == 3) unit_done = 3'b010;
         #1;
         checks++; if (stall !== 1'b1 || unit_start !== 3'b000 || result_valid !== 1'b0) begin
            errors++; $display("FAIL basic_wait%0d: stall=%b start=%b rv=%b want 1 000 0", i, stall, unit_start, result_valid);
         end
      end
      tick();
      unit_done = '0; issue_valid = 1'b0;
      #1;
      checks++; if (result_valid !== 1'b1 || stall !== 1'b0) begin errors++; $display("FAIL basic_done: rv=%b stall=%b want 1 0", result_valid, stall); end
      if (result_valid === 1'b1) begin
         checks++;
         if (sb_q.size() == 0) begin errors++; $display("FAIL basic_sb: result_valid with empty scoreboard"); end
         else begin exp_res = sb_q.pop_front(); if (result !== exp_res) begin errors++; $display("FAIL basic_result: got %h want %h", result, exp_res); end end
      end
      exp_sc += 4;
      checks++; if (stall_cycles !== exp_sc) begin errors++; $display("FAIL basic_stall_cycles: got %0d want %0d", stall_cycles, exp_sc); end
      tick();
      #1;
      checks++; if (result_valid !== 1'b0 || result !== 64'hDEAD_BEEF) begin errors++; $display("FAIL basic_hold: rv=%b result=%h want 0 deadbeef", result_valid, result); end
   endtask

   task automatic test_back_to_back();
      int starts;
      starts = 0;
      issue_valid = 1'b1; issue_unit = 2'd0;
      unit_result[0*W +: W] = 64'h0123_4567_89AB_CDEF;
      sb_q.push_back(64'h0123_4567_89AB_CDEF);
      for (int c = 0; c < 4; c++) begin
         if (c > 0) tick();
         unit_done = (c == 2) ? 3'b001 : 3'b000;
         #1;
         if (unit_start != 3'b000) starts++;
         if (c == 3) begin
            checks++; if (stall !== 1'b0 || result_valid !== 1'b1) begin errors++; $display("FAIL b2b_done: stall=%b rv=%b want 0 1", stall, result_valid); end
            if (result_valid === 1'b1) begin
               checks++;
               if (sb_q.size() == 0) begin errors++; $display("FAIL b2b_sb: result_valid with empty scoreboard"); end
               else begin exp_res = sb_q.pop_front(); if (result !== exp_res) begin errors++; $display("FAIL b2b_result: got %h want %h", result, exp_res); end end
            end
         end
      end
      checks++; if (starts !== 1) begin errors++; $display("FAIL b2b_one_start: got %0d pulses want 1", starts); end
      tick();
      issue_unit = 2'd2;
      unit_result[2*W +: W] = 64'hFEED_0000_0000_0002;
      sb_q.push_back(64'hFEED_0000_0000_0002);
      #1;
      checks++; if (unit_start !== 3'b100 || stall !== 1'b1) begin errors++; $display("FAIL b2b_relaunch: start=%b stall=%b want 100 1", unit_start, stall); end
      tick();
      unit_done = 3'b100;
      tick();
      unit_done = '0; issue_valid = 1'b0;
      #1;
      if (result_valid === 1'b1) begin
         checks++;
         if (sb_q.size() == 0) begin errors++; $display("FAIL b2b_sb2: result_valid with empty scoreboard"); end
         else begin exp_res = sb_q.pop_front(); if (result !== exp_res) begin errors++; $display("FAIL b2b_result2: got %h want %h", result, exp_res); end end
      end else begin
         checks++; errors++; $display("FAIL b2b_rv2: got 0 want 1");
      end
      exp_sc += 5;
      checks++; if (stall_cycles !== exp_sc) begin errors++; $display("FAIL b2b_stall_cycles: got %0d want %0d", stall_cycles, exp_sc); end
   endtask

   task automatic test_ignore_other();
      tick();
      issue_valid = 1'b1; issue_unit = 2'd1;
      unit_result[1*W +: W] = 64'hC0C0_C0C0_0000_0003;
      unit_result[0*W +: W] = 64'hBAD0_BAD0_BAD0_BAD0;
      sb_q.push_back(64'hC0C0_C0C0_0000_0003);
      tick();
      unit_done = 3'b001;
      tick();
      unit_done = '0;
      #1;
      checks++; if (stall !== 1'b1 || result_valid !== 1'b0) begin errors++; $display("FAIL ignore_stray: stall=%b rv=%b want 1 0", stall, result_valid); end
      tick();
      unit_done = 3'b010;
      tick();
      unit_done = '0; issue_valid = 1'b0;
      #1;
      if (result_valid === 1'b1) begin
         checks++;
         if (sb_q.size() == 0) begin errors++; $display("FAIL ignore_sb: result_valid with empty scoreboard"); end
         else begin exp_res = sb_q.pop_front(); if (result !== exp_res) begin errors++; $display("FAIL ignore_result: got %h want %h", result, exp_res); end end
      end else begin
         checks++; errors++; $display("FAIL ignore_rv: got 0 want 1");
      end
      exp_sc += 4;
      checks++; if (stall_cycles !== exp_sc) begin errors++; $display("FAIL ignore_stall_cycles: got %0d want %0d", stall_cycles, exp_sc); end
   endtask

   task automatic test_flush_drain();
      tick();
      issue_valid = 1'b1; issue_unit = 2'd0;
      unit_result[0*W +: W] = 64'hDDDD_DDDD_DDDD_DDDD;
      #1;
      checks++; if (unit_start !== 3'b001) begin errors++; $display("FAIL flush_start: got %b want 001", unit_start); end
      tick();
      tick();
      flush = 1'b1;
      #1;
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL flush_stall: got %b want 1", stall); end
      tick();
      flush = 1'b0; issue_valid = 1'b0;
      #1;
      checks++; if (stall !== 1'b0 || result_valid !== 1'b0 || result !== 64'hC0C0_C0C0_0000_0003) begin
         errors++; $display("FAIL flush_drain: stall=%b rv=%b result=%h want 0 0 c0c0c0c000000003", stall, result_valid, result);
      end
      tick();
      unit_done = 3'b001; issue_valid = 1'b1; issue_unit = 2'd2;
      #1;
      checks++; if (stall !== 1'b1 || unit_start !== 3'b000 || result_valid !== 1'b0) begin
         errors++; $display("FAIL flush_drain_issue: stall=%b start=%b rv=%b want 1 000 0", stall, unit_start, result_valid);
      end
      tick();
      unit_done = '0;
      unit_result[2*W +: W] = 64'hEEEE_0000_0000_0005;
      sb_q.push_back(64'hEEEE_0000_0000_0005);
      #1;
      checks++; if (unit_start !== 3'b100 || stall !== 1'b1) begin errors++; $display("FAIL flush_idle_again: start=%b stall=%b want 100 1", unit_start, stall); end
      tick();
      unit_done = 3'b100;
      tick();
      unit_done = '0; issue_valid = 1'b0;
      #1;
      if (result_valid === 1'b1) begin
         checks++;
         if (sb_q.size() == 0) begin errors++; $display("FAIL flush_sb: result_valid with empty scoreboard"); end
         else begin exp_res = sb_q.pop_front(); if (result !== exp_res) begin errors++; $display("FAIL flush_result: got %h want %h", result, exp_res); end end
      end else begin
         checks++; errors++; $display("FAIL flush_rv: got 0 want 1");
      end
      exp_sc += 6;
      checks++; if (stall_cycles !== exp_sc) begin errors++; $display("FAIL flush_stall_cycles: got %0d want %0d", stall_cycles, exp_sc); end
   endtask

   task automatic test_flush_with_done();
      tick();
      issue_valid = 1'b1; issue_unit = 2'd1;
      unit_result[1*W +: W] = 64'h1111_2222_3333_4444;
      tick();
      flush = 1'b1; unit_done = 3'b010;
      tick();
      flush = 1'b0; unit_done = '0; issue_unit = 2'd0;
      unit_result[0*W +: W] = 64'hF0F0_F0F0_0000_0006;
      sb_q.push_back(64'hF0F0_F0F0_0000_0006);
      #1;
      checks++; if (unit_start !== 3'b001 || result_valid !== 1'b0 || result !== 64'hEEEE_0000_0000_0005) begin
         errors++; $display("FAIL fwd_idle: start=%b rv=%b result=%h want 001 0 eeee000000000005", unit_start, result_valid, result);
      end
      tick();
      unit_done = 3'b001;
      tick();
      unit_done = '0; issue_valid = 1'b0;
      #1;
      if (result_valid === 1'b1) begin
         checks++;
         if (sb_q.size() == 0) begin errors++; $display("FAIL fwd_sb: result_valid with empty scoreboard"); end
         else begin exp_res = sb_q.pop_front(); if (result !== exp_res) begin errors++; $display("FAIL fwd_result: got %h want %h", result, exp_res); end end
      end else begin
         checks++; errors++; $display("FAIL fwd_rv: got 0 want 1");
      end
      // flush arriving in DONE must hide the result
      tick();
      issue_valid = 1'b1; issue_unit = 2'd2;
      unit_result[2*W +: W] = 64'h7777_7777_7777_7777;
      tick();
      unit_done = 3'b100;
      tick();
      unit_done = '0; flush = 1'b1;
      #1;
      checks++; if (result_valid !== 1'b0 || stall !== 1'b0 || unit_start !== 3'b000) begin
         errors++; $display("FAIL done_flush: rv=%b stall=%b start=%b want 0 0 000", result_valid, stall, unit_start);
      end
      tick();
      flush = 1'b0; issue_valid = 1'b0;
      #1;
      exp_sc += 6;
      checks++; if (stall_cycles !== exp_sc) begin errors++; $display("FAIL fwd_stall_cycles: got %0d want %0d", stall_cycles, exp_sc); end
   endtask

   task automatic test_err_reset();
      tick();
      issue_valid = 1'b1; issue_unit = 2'd3;
      #1;
      checks++; if (issue_err !== 1'b1 || unit_start !== 3'b000 || stall !== 1'b0) begin
         errors++; $display("FAIL err_issue: err=%b start=%b stall=%b want 1 000 0", issue_err, unit_start, stall);
      end
      tick();
      #1;
      checks++; if (issue_err !== 1'b1 || unit_start !== 3'b000) begin errors++; $display("FAIL err_stay_idle: err=%b start=%b want 1 000", issue_err, unit_start); end
      tick();
      issue_unit = 2'd1;
      #1;
      checks++; if (unit_start !== 3'b010 || issue_err !== 1'b0) begin errors++; $display("FAIL err_recover: start=%b err=%b want 010 0", unit_start, issue_err); end
      tick();
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1; issue_valid = 1'b0;
      #1;
      exp_sc = 0;
      checks++; if (unit_start !== 3'b000 || stall !== 1'b0 || result !== 64'd0 || result_valid !== 1'b0 || issue_err !== 1'b0 || timeout !== 1'b0) begin
         errors++; $display("FAIL midreset_outputs: start=%b stall=%b result=%h rv=%b err=%b to=%b want all 0", unit_start, stall, result, result_valid, issue_err, timeout);
      end
      checks++; if (stall_cycles !== exp_sc) begin errors++; $display("FAIL midreset_stall_cycles: got %0d want 0", stall_cycles); end
      tick();
      unit_done = 3'b010;
      #1;
      checks++; if (stall !== 1'b0 || unit_start !== 3'b000) begin errors++; $display("FAIL stale_done: stall=%b start=%b want 0 000", stall, unit_start); end
      tick();
      unit_done = '0;
      #1;
      checks++; if (result_valid !== 1'b0 || result !== 64'd0) begin errors++; $display("FAIL stale_result: rv=%b result=%h want 0 0", result_valid, result); end
   endtask

`ifdef MCU_TIMEOUT_EN
   task automatic test_timeout();
      tick();
      issue_valid = 1'b1; issue_unit = 2'd2;
      unit_result[2*W +: W] = 64'h4848_4848_4848_4848;
      sb_q.push_back(64'h4848_4848_4848_4848);
      tick();
      unit_done = 3'b100;
      tick();
      unit_done = '0; issue_valid = 1'b0;
      #1;
      if (result_valid === 1'b1) begin
         checks++;
         if (sb_q.size() == 0) begin errors++; $display("FAIL to_sb: result_valid with empty scoreboard"); end
         else begin exp_res = sb_q.pop_front(); if (result !== exp_res) begin errors++; $display("FAIL to_pre_result: got %h want %h", result, exp_res); end end
      end else begin
         checks++; errors++; $display("FAIL to_pre_rv: got 0 want 1");
      end
      tick();
      issue_valid = 1'b1; issue_unit = 2'd0;
      #1;
      checks++; if (unit_start !== 3'b001) begin errors++; $display("FAIL to_start: got %b want 001", unit_start); end
      for (int i = 1; i <= 8; i++) begin
         tick();
         #1;
         checks++; if (timeout !== 1'b0 || stall !== 1'b1) begin errors++; $display("FAIL to_wait%0d: timeout=%b stall=%b want 0 1", i, timeout, stall); end
      end
      tick();
      issue_valid = 1'b0;
      #1;
      checks++; if (timeout !== 1'b1 || result !== 64'd0 || result_valid !== 1'b0 || stall !== 1'b0) begin
         errors++; $display("FAIL to_fire: timeout=%b result=%h rv=%b stall=%b want 1 0 0 0", timeout, result, result_valid, stall);
      end
      tick();
      issue_valid = 1'b1; issue_unit = 2'd2;
      #1;
      checks++; if (timeout !== 1'b0 || unit_start !== 3'b000 || stall !== 1'b1) begin
         errors++; $display("FAIL to_drain: timeout=%b start=%b stall=%b want 0 000 1", timeout, unit_start, stall);
      end
      tick();
      unit_done = 3'b001; issue_valid = 1'b0;
      tick();
      unit_done = '0;
      #1;
      checks++; if (stall !== 1'b0 || result_valid !== 1'b0) begin errors++; $display("FAIL to_idle: stall=%b rv=%b want 0 0", stall, result_valid); end
   endtask
`endif

   initial begin
      checks = 0;
      errors = 0;
      exp_sc = 0;
      test_reset();
      test_basic();
      test_back_to_back();
      test_ignore_other();
      test_flush_drain();
      test_flush_with_done();
      test_err_reset();
`ifdef MCU_TIMEOUT_EN
      test_timeout();
`endif
      checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL sb_empty: %0d results never seen, want 0", sb_q.size()); end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/multicycle_exec_ctrl.md
Name: multicycle_exec_ctrl

Overview:
Generalised execute-stage sequencer for NUM_UNITS multi-cycle functional units (multiplier, divider, and future units).
- Launches the selected unit with a one-cycle start pulse.
- Freezes the front pipeline via stall until that unit reports done.
- Registers and presents the unit's result for exactly one non-stalled cycle.
- Supports flush and drain of an in-flight op, and keeps a saturating stall-cycle count.
- Sits between the EX pipeline wall and the multi-cycle units; its stall feeds the PC and wall enables.

Parameters:
NUM_UNITS, 2, number of attached multi-cycle units (1..16)
WIDTH, 64, result datapath width
SEL_W, $clog2(NUM_UNITS) (min 1), derived unit-select width; do not override
TIMEOUT_CYCLES, 256, watchdog limit in WAIT; used only with MCU_TIMEOUT_EN

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  synchronous, active-low reset
issue_valid  in  1  op in EX requires a multi-cycle unit
issue_unit  in  SEL_W  index of the requested unit
flush  in  1  abort the in-flight op (branch/exception squash)
unit_start  out  NUM_UNITS  one-hot, one-cycle launch pulse
unit_done  in  NUM_UNITS  per-unit one-cycle completion pulse
unit_result  in  NUM_UNITS*WIDTH  packed results; unit i at [i*WIDTH +: WIDTH]
stall  out  1  hold PC and pipeline walls
result  out  WIDTH  registered result of the completed op
result_valid  out  1  result valid this cycle
issue_err  out  1  issue_unit >= NUM_UNITS this cycle
timeout  out  1  op ended by watchdog (only with MCU_TIMEOUT_EN; otherwise tied to 0)
stall_cycles  out  32  saturating count of cycles with stall=1

Behaviour:
Reset: reset_n=0 at a clock edge forces state IDLE, result=0, sel register=0, stall_cycles=0, watchdog=0. All combinational outputs are 0 while in IDLE with no issue. Reset mid-operation abandons the op; late unit_done pulses are ignored after reset.

States: IDLE, WAIT, DONE, DRAIN.
- IDLE:
  - issue_valid=1 with a valid index: unit_start[issue_unit]=1 and stall=1 in the same cycle; latch issue_unit into sel; next state WAIT.
  - Out-of-range index: issue_err=1, no start, stall=0, stay in IDLE.
  - flush in IDLE has no effect.
- WAIT:
  - stall=1.
  - unit_done[sel]=1: capture unit_result[sel] into result; next state DONE.
  - Done pulses from unselected units are ignored.
  - flush=1 with no unit_done[sel]: next state DRAIN.
  - flush=1 together with unit_done[sel]: the flush wins; result is not updated; next state IDLE.
- DONE:
  - stall=0, result_valid=1, no unit_start even though issue_valid is still high for the same instruction; next state IDLE unconditionally.
  - flush in DONE suppresses result_valid.
  - Issue-to-result_valid latency = unit latency + 2 cycles; minimum total stall = unit latency + 1 cycles.
- DRAIN:
  - stall=issue_valid.
  - Waits for unit_done[sel] from the aborted unit; next state IDLE. The result is discarded.
  - No new start is issued until IDLE.
- A unit_done arriving in the same cycle as unit_start is ignored; units must have latency >= 1.
- stall_cycles increments every cycle stall=1 and saturates at 2^32-1.
- result holds its last value outside DONE.

Optional Feature:
Macro MCU_TIMEOUT_EN.
- Defined: a watchdog counter clears on entry to WAIT and increments each WAIT cycle. When it reaches TIMEOUT_CYCLES with no done, the controller:
  - sets result=0;
  - goes to DRAIN, with timeout=1 for one cycle;
  - asserts no result_valid.
- Not defined: no counter is built, timeout=0, and WAIT can last indefinitely.

Decomposition:
Package mcu_pkg:
- state enum mcu_state_e {IDLE, WAIT, DONE, DRAIN};
- STALL_CNT_W=32;
- helper function for the safe clog2 minimum of 1.

Sub-module sat_counter (parameter W; ports clk, reset_n, clr, inc, count) is used for both stall_cycles and the watchdog.

Test Plan:
1. NUM_UNITS=2, issue unit 1, unit_done[1] 3 cycles after the start pulse with result 0xDEAD_BEEF -> unit_start=2'b10 for one cycle; stall high 4 cycles; result_valid=1 with result=0xDEAD_BEEF in the 5th cycle; stall_cycles=4.
2. Hold issue_valid high through DONE -> exactly one unit_start pulse; stall low in DONE; back-to-back new issue launches the cycle after DONE.
3. unit_done[0] pulses while waiting on unit 1 -> ignored, still stalled; a later unit_done[1] completes normally.
4. flush in the 2nd WAIT cycle, done 2 cycles later with issue_valid=0 -> DRAIN, stall=0, no result_valid, result unchanged; IDLE after the done.
5. issue_unit=3 with NUM_UNITS=3 -> issue_err=1, unit_start=0, stall=0; reset_n=0 during WAIT -> all outputs 0 next cycle; a stale done afterwards is ignored.
6. MCU_TIMEOUT_EN with TIMEOUT_CYCLES=8, no done -> timeout pulse after 8 WAIT cycles, result=0, no result_valid, DRAIN entered.
